iterative_shifter: RTL and testbench

- Multi-cycle shift unit that consumes the 5-bit shift amount (instruction bits 10:6, zero-padded) that the immediate/shamt extender produces for R-type shifts.
- Also accepts a register-sourced amount for the variable-shift instructions (SLLV, SRLV, SRAV).
- Shifts one bit position per clock, so the ALU path stays short. The multi-cycle control FSM stalls on busy until done.

---
 rtl/iterative_shifter_pkg.sv | 21 ++
 rtl/iterative_shifter_if.sv | 32 +++
 rtl/iterative_shifter_step.sv | 27 ++
 rtl/iterative_shifter.sv | 83 ++++++++
 tb/tb_iterative_shifter.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/iterative_shifter_pkg.sv
// Shared definitions for the iterative shifter.
// Holds the shift operation encodings and the controller state encodings.
// The state encodings are plain 2-bit constants so they can be compared with
// older netlists and waveforms that use the same numeric values.
package shifter_pkg;

    typedef logic [1:0] sh_op_t;
    typedef logic [1:0] state_t;

    // Shift operation encodings (the op port)
    localparam sh_op_t SH_SLL  = 2'b00;
    localparam sh_op_t SH_SRL  = 2'b01;
    localparam sh_op_t SH_SRA  = 2'b10;
    localparam sh_op_t SH_ROTR = 2'b11;

    // Controller states
    localparam state_t ST_IDLE  = 2'b00;
    localparam state_t ST_SHIFT = 2'b01;
    localparam state_t ST_DONE  = 2'b10;

endpackage

// File: rtl/iterative_shifter_if.sv
// Request/result bundle for the iterative shifter.
// Signals:
//   start   - request a shift (accepted only in IDLE or DONE)
//   op      - 00 SLL, 01 SRL, 10 SRA, 11 ROTR
//   operand - value to shift
//   shamt   - shift amount
//   result  - shifted value, valid while done=1 and held until the next accepted start
//   busy    - high while shifting
//   done    - one-cycle pulse, result valid
// The master modport belongs to the requester, the slave modport to the shifter.
interface iterative_shifter_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [1:0]         op;
    logic [WIDTH-1:0]   operand;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   result;
    logic               busy;
    logic               done;

    modport master (
        output start, op, operand, shamt,
        input  result, busy, done
    );

    modport slave (
        input  start, op, operand, shamt,
        output result, busy, done
    );
endinterface

// File: rtl/iterative_shifter_step.sv
// Combinational single-bit shift step.
// Ports:
//   op_i - operation select (SLL, SRL, SRA, ROTR)
//   w_i  - current work value
//   w_o  - work value after one bit position of the selected operation
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] w_i,
    output logic [WIDTH-1:0] w_o
);

    always_comb begin
        w_o = w_i;
        case (op_i)
            SH_SLL:  w_o = {w_i[WIDTH-2:0], 1'b0};
            SH_SRL:  w_o = {1'b0, w_i[WIDTH-1:1]};
            SH_SRA:  w_o = {w_i[WIDTH-1], w_i[WIDTH-1:1]};
            SH_ROTR: w_o = {w_i[0], w_i[WIDTH-1:1]};
            default: w_o = w_i;
        endcase
    end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: one bit position per clock.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset; aborts any operation in progress
//   bus   - request/result bundle (start, op, operand, shamt, result, busy, done)
// A request is latched in IDLE or DONE; the work register then shifts once per
// clock while count runs down, and done pulses for one cycle with the result.
// Accepting in DONE allows back-to-back operations without an IDLE bubble.
module iterative_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    iterative_shifter_if.slave bus
);

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    sh_op_t             op_q, op_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   step_w;
    logic               accept;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op_i (op_q),
        .w_i  (work_q),
        .w_o  (step_w)
    );

    // start is only honoured when no shift is running; it is ignored in SHIFT
    assign accept = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        work_d  = work_q;

        case (state_q)
            ST_IDLE:  state_d = ST_IDLE;
            ST_SHIFT: begin
                work_d  = step_w;
                count_d = count_q - SHAMT_W'(1);
                // Leaving at count==1 means count never wraps below zero
                if (count_q == SHAMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (accept) begin
            work_d  = bus.operand;
            count_d = bus.shamt;
            op_d    = bus.op;
            // A zero amount needs no steps: the operand is already the result
            state_d = (bus.shamt == '0) ? ST_DONE : ST_SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            op_q    <= SH_SLL;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            work_q  <= work_d;
        end
    end

    assign bus.result = work_q;
    assign bus.busy   = (state_q == ST_SHIFT);
    assign bus.done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_iterative_shifter.sv
// Self-checking bench for iterative_shifter: directed cases followed by
// randomized operations compared against a plain-arithmetic shift model.
module tb_iterative_shifter;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    iterative_shifter_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

    iterative_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the whole shift computed in one go from the operation rules
    function automatic logic [31:0] ref_shift(input logic [1:0] op,
                                              input logic [31:0] x,
                                              input logic [4:0] s);
        logic signed [31:0] sx;
        sx = x;
        case (op)
            2'b00:   return x << s;
            2'b01:   return x >> s;
            2'b10:   return sx >>> s;
            default: return (s == 5'd0) ? x : ((x >> s) | (x << (6'd32 - {1'b0, s})));
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE or DONE and follow it to its done cycle.
    // Inputs are scrambled during the shift to prove they were latched; with
    // poke set, a stray start is pulsed mid-shift and must be ignored.
    task automatic run_op(input logic [1:0] op, input logic [31:0] x,
                          input logic [4:0] s, input bit poke,
                          input string tag, output logic [31:0] exp);
        exp         = ref_shift(op, x, s);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.operand = x;
        bus.shamt   = s;
        step();
        for (int k = 0; k < int'(s); k++) begin
            chk({tag, " busy"}, 32'(bus.busy), 32'd1);
            chk({tag, " early done"}, 32'(bus.done), 32'd0);
            if (poke && k == 2) begin
                bus.start   = 1'b1;
                bus.op      = 2'b00;
                bus.operand = 32'h1;
                bus.shamt   = 5'd1;
            end else begin
                bus.start   = 1'b0;
                bus.op      = 2'($urandom);
                bus.operand = $urandom;
                bus.shamt   = 5'($urandom);
            end
            step();
        end
        bus.start = 1'b0;
        chk({tag, " done"}, 32'(bus.done), 32'd1);
        chk({tag, " busy at done"}, 32'(bus.busy), 32'd0);
        chk({tag, " result"}, bus.result, exp);
    endtask

    // One cycle after done with no new start: idle, no second pulse, result held
    task automatic idle_check(input string tag, input logic [31:0] exp);
        step();
        chk({tag, " done dropped"}, 32'(bus.done), 32'd0);
        chk({tag, " busy idle"}, 32'(bus.busy), 32'd0);
        chk({tag, " result held"}, bus.result, exp);
    endtask

    initial begin
        logic [31:0] exp;
        logic [1:0]  rop;
        logic [31:0] rx;
        logic [4:0]  rs;
        bit          b2b;

        n_cmp       = 0;
        n_err       = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.operand = '0;
        bus.shamt   = '0;
        step();
        step();
        chk("reset result", bus.result, 32'h0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        step();
        chk("idle done", 32'(bus.done), 32'd0);

        // Reset in the middle of a long shift
        bus.start   = 1'b1;
        bus.op      = 2'b00;
        bus.operand = 32'h1;
        bus.shamt   = 5'd20;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("pre-reset busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset result", bus.result, 32'h0);
        chk("midreset busy", 32'(bus.busy), 32'd0);
        chk("midreset done", 32'(bus.done), 32'd0);
        for (int k = 0; k < 24; k++) begin
            step();
            chk("post-reset no done", 32'(bus.done), 32'd0);
        end

        // Directed cases
        run_op(2'b00, 32'h0000_0001, 5'd31, 1'b0, "sll31", exp);
        chk("sll31 value", exp, 32'h8000_0000);
        idle_check("sll31", exp);
        run_op(2'b00, 32'hDEAD_BEEF, 5'd0, 1'b0, "sll0", exp);
        chk("sll0 value", bus.result, 32'hDEAD_BEEF);
        idle_check("sll0", exp);
        run_op(2'b01, 32'hF000_0000, 5'd4, 1'b0, "srl4", exp);
        chk("srl4 value", bus.result, 32'h0F00_0000);
        idle_check("srl4", exp);
        run_op(2'b10, 32'hF000_0000, 5'd4, 1'b0, "sra4", exp);
        chk("sra4 value", bus.result, 32'hFF00_0000);
        idle_check("sra4", exp);
        run_op(2'b11, 32'h0000_0003, 5'd1, 1'b0, "rotr1", exp);
        chk("rotr1 value", bus.result, 32'h8000_0001);
        idle_check("rotr1", exp);
        run_op(2'b01, 32'h8000_0000, 5'd8, 1'b1, "poke", exp);
        chk("poke value", bus.result, 32'h0080_0000);
        idle_check("poke", exp);

        // Back-to-back: second start issued in the DONE cycle of the first
        run_op(2'b10, 32'h8765_4321, 5'd3, 1'b0, "b2b first", exp);
        run_op(2'b00, 32'h0000_0001, 5'd2, 1'b0, "b2b second", exp);
        chk("b2b value", bus.result, 32'h0000_0004);
        idle_check("b2b", exp);

        // Randomized operations, some back-to-back, some with idle gaps
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            rx  = $urandom;
            case ($urandom_range(0, 5))
                0:       rs = 5'd0;
                1:       rs = 5'd31;
                default: rs = 5'($urandom);
            endcase
            b2b = 1'($urandom);
            run_op(rop, rx, rs, 1'($urandom), "rand", exp);
            if (!b2b) idle_check("rand", exp);
        end
        idle_check("final", exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
